avalon_gpio_ext: RTL and testbench
==================================

AVALON_GPIO_EXT -- requirements
Module: avalon_gpio_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 18: pin count, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000: stable-cycle count, used only with GPIO_DEBOUNCE_EN.
REQ-004 SHALL have parameter RESET_OUT, default 0: data_out reset value, WIDTH bits.
REQ-005 SHALL have ports:
- clk  input  1  sole clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request.
- bidir_port  inout  WIDTH  pins.

Function
REQ-006 SHALL decode a write as chipselect && !write_n; writes SHALL take effect on the next clk edge.
REQ-007 SHALL use this address map:
- 0: read pin_in; write data_out.
- 1: direction (1 = drive).
- 2: irq_mask.
- 3: edge_capture; read value; write 1 clears that bit.
- 4: outset; write 1 sets data_out bits; reads 0.
- 5: outclear; write 1 clears data_out bits; reads 0.
- 6: rise_en.
- 7: fall_en.
REQ-008 SHALL register readdata every cycle from the current address, regardless of chipselect, giving 1-cycle read latency; bits 31:WIDTH SHALL read 0.
REQ-009 SHALL drive bidir_port[i] = data_out[i] when direction[i] = 1, else high-Z.
REQ-010 SHALL pass bidir_port through SYNC_STAGES flops to form pin_in.
REQ-011 SHALL keep one further delayed copy, pin_prev, and set edge_capture[i] on:
- (rise_en[i] && pin_in[i] && !pin_prev[i]), or
- (fall_en[i] && !pin_in[i] && pin_prev[i]).
REQ-012 SHALL let set win when an edge and a write-1-clear hit the same bit in the same cycle, so no event is lost.
REQ-013 SHALL hold edge_capture bits until cleared; bits SHALL NOT be cleared by read.
REQ-014 SHALL drive irq combinationally as |(edge_capture & irq_mask).
REQ-015 SHALL detect edges on output-direction pins too, since they read back their own drive.

Reset
REQ-016 SHALL, on reset_n low, asynchronously set:
- data_out = RESET_OUT.
- direction, irq_mask, edge_capture, rise_en, fall_en, readdata = 0.
- all synchroniser, pin_prev and debounce state = 0.
REQ-017 SHALL NOT flag an edge for an input that is high when reset is released, because rise_en = 0 after reset.

Configuration
REQ-018 SHALL, with GPIO_DEBOUNCE_EN defined, insert a per-pin debouncer between synchroniser and pin_in:
- pin_in[i] updates only after the synchronised value differs from pin_in[i] for DEBOUNCE_CYCLES consecutive cycles.
- any glitch restarts that pin's counter.
- counter width is $clog2(DEBOUNCE_CYCLES+1).
REQ-019 SHALL, without GPIO_DEBOUNCE_EN, connect the synchroniser output directly to pin_in, with no counters and DEBOUNCE_CYCLES ignored.

Structure
REQ-020 SHALL place the address constants (ADDR_DATA .. ADDR_FALL_EN) and the maximum WIDTH in shared package gpio_pkg.
REQ-021 SHALL implement the per-pin debouncer as sub-module gpio_debounce, instantiated WIDTH times under GPIO_DEBOUNCE_EN.

Verification
REQ-022 Bench SHALL cover direction/output: write dir=0x3FFFF, data=0x2A5A5, then read addr 0 -> readdata=0x2A5A5 one cycle after the address is presented; bidir_port driven to 0x2A5A5.
REQ-023 Bench SHALL cover set/clear: with data_out=0x00F0, write outset=0x000F then outclear=0x00C0 -> data_out=0x003F; a read of addr 4 returns 0.
REQ-024 Bench SHALL cover edge select:
- rise_en=0x1, fall_en=0x2, irq_mask=0x3.
- drive pin0 0->1 -> edge_capture=0x1 and irq=1 after SYNC_STAGES+1 cycles.
- drive pin1 1->0 -> edge_capture=0x3.
- write addr3=0x1 -> edge_capture=0x2.
REQ-025 Bench SHALL cover the simultaneous case: a rising edge on pin0 in the same cycle as a write-1 to addr3 bit0 -> edge_capture[0] stays 1.
REQ-026 Bench SHALL cover debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8):
- a 5-cycle pulse on pin3 -> no change to pin_in or edge_capture.
- a 12-cycle high on pin3 -> pin_in[3]=1 eight cycles after the synchronised value changes.
REQ-027 Bench SHALL cover reset mid-operation: assert reset_n low with irq=1 and data_out=0x1234 -> irq=0, data_out=RESET_OUT and bidir_port all high-Z immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared register map and sizing limits for the Avalon GPIO
//               extension block.
// Contents    : ADDR_* register offsets, MAX_WIDTH pin-count ceiling,
//               edge_event() helper used for edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd7;

  localparam int MAX_WIDTH = 32;

  // Per-bit edge event: rising edges where rise is enabled, falling edges
  // where fall is enabled. Operates on full MAX_WIDTH vectors; callers
  // zero-extend narrower buses.
  function automatic logic [MAX_WIDTH-1:0] edge_event(
    input logic [MAX_WIDTH-1:0] cur,
    input logic [MAX_WIDTH-1:0] prev,
    input logic [MAX_WIDTH-1:0] rise,
    input logic [MAX_WIDTH-1:0] fall
  );
    return (rise & cur & ~prev) | (fall & ~cur & prev);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : Single-pin debouncer. The output follows the input only after
//               the input has differed from the output for CYCLES consecutive
//               clocks; any return to the current output value restarts the
//               count.
// Ports       : clk      - clock
//               reset_n  - asynchronous active-low reset
//               din      - synchronised pin value
//               dout     - debounced pin value
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int               CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds how many consecutive cycles din has already disagreed with
  // dout; the CYCLES-th disagreeing cycle commits the new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_gpio_ext.sv
`default_nettype none
// ============================================================================
// Module      : avalon_gpio_ext
// Description : Avalon-MM GPIO block with per-pin direction, atomic set/clear
//               of the output register, selectable rising/falling edge
//               capture and a masked level interrupt.
// Option      : define GPIO_DEBOUNCE_EN to insert a per-pin debouncer
//               (DEBOUNCE_CYCLES stable cycles) between the synchroniser and
//               pin_in. Without it the synchroniser feeds pin_in directly.
// Ports       : clk        - sole clock
//               reset_n    - asynchronous active-low reset
//               address    - register select (0..7)
//               chipselect - slave select
//               write_n    - active-low write strobe
//               writedata  - 32-bit write data
//               readdata   - registered read data, 1-cycle latency
//               irq        - |(edge_capture & irq_mask), combinational
//               bidir_port - WIDTH tristate pins
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_gpio_ext
  import gpio_pkg::*;
#(
  parameter int               WIDTH           = 18,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 0) begin : g_bad_param
    $error("avalon_gpio_ext: illegal parameter value");
  end

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] pin_prev;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [MAX_WIDTH-1:0] edge_full;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign wdata            = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // --------------------------------------------------------------------------
  // Pads
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = direction[i] ? data_out[i] : 1'bz;
  end

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bidir_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    gpio_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync_out[i]),
      .dout    (pin_in[i])
    );
  end
`else
  assign pin_in = sync_out;
`endif

  // --------------------------------------------------------------------------
  // Edge detection. Output pins are included: they read back their own drive.
  // --------------------------------------------------------------------------
  assign edge_full = edge_event(MAX_WIDTH'(pin_in), MAX_WIDTH'(pin_prev),
                                MAX_WIDTH'(rise_en), MAX_WIDTH'(fall_en));
  assign edge_set  = edge_full[WIDTH-1:0];
  assign edge_clr  = (wr_en && address == ADDR_EDGE_CAPTURE) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_prev     <= '0;
      edge_capture <= '0;
    end else begin
      pin_prev     <= pin_in;
      // Set is applied after clear so a same-cycle edge is never lost.
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_OUT;
      direction <= '0;
      irq_mask  <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:      data_out  <= wdata;
        ADDR_DIRECTION: direction <= wdata;
        ADDR_IRQ_MASK:  irq_mask  <= wdata;
        ADDR_OUTSET:    data_out  <= data_out | wdata;
        ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
        ADDR_RISE_EN:   rise_en   <= wdata;
        ADDR_FALL_EN:   fall_en   <= wdata;
        default:        ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read path: registered every cycle from the current address.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:         rd_mux[WIDTH-1:0] = pin_in;
      ADDR_DIRECTION:    rd_mux[WIDTH-1:0] = direction;
      ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
      ADDR_RISE_EN:      rd_mux[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN:      rd_mux[WIDTH-1:0] = fall_en;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_gpio_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_gpio_ext
// Description : Directed self-checking bench for avalon_gpio_ext. Reads push
//               their expected value into a scoreboard queue; a monitor pops
//               and compares when the registered read data becomes valid.
//               Pin and irq levels are compared directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_gpio_ext;

  localparam int          W    = 18;
  localparam int          SS   = 2;
  localparam int          DB   = 8;
  localparam logic [17:0] RST_OUT = 18'h00055;
`ifdef GPIO_DEBOUNCE_EN
  localparam int          LAT  = SS + DB;
`else
  localparam int          LAT  = SS;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  wire  [W-1:0]  pins;

  logic [W-1:0]  tb_oe;
  logic [W-1:0]  tb_drv;

  for (genvar i = 0; i < W; i++) begin : g_tbpad
    assign pins[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end

  avalon_gpio_ext #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .RESET_OUT       (RST_OUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (pins)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_item;
  logic     rd_req   = 1'b0;
  logic     rd_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Read data is valid on the cycle after the address was presented.
  always @(posedge clk) rd_valid <= rd_req;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%0h expected no read", readdata);
      end else begin
        mon_item = sb.pop_front();
        check(mon_item.name, readdata, mon_item.exp);
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
    sb.push_back('{name: nm, exp: exp});
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_req     = 1'b1;
    @(posedge clk); #1;
    rd_req     = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tb_oe      = '1;
    tb_drv     = '0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    settle();

    // Reset state
    check("irq_reset", {31'd0, irq}, 32'd0);
    bus_read(3'd0, 32'h0, "rst_pin_in");
    bus_read(3'd1, 32'h0, "rst_direction");
    bus_read(3'd2, 32'h0, "rst_irq_mask");
    bus_read(3'd3, 32'h0, "rst_edge_capture");
    bus_read(3'd6, 32'h0, "rst_rise_en");
    bus_read(3'd7, 32'h0, "rst_fall_en");

    // Direction / output
    tb_oe = '0;
    bus_write(3'd1, 32'h3FFFF);
    check("pins_reset_out", {14'd0, pins}, {14'd0, RST_OUT});
    bus_write(3'd0, 32'h2A5A5);
    check("pins_drive", {14'd0, pins}, 32'h2A5A5);
    settle();
    bus_read(3'd0, 32'h2A5A5, "rd_pin_in_drive");
    bus_read(3'd1, 32'h3FFFF, "rd_direction");

    // Set / clear
    bus_write(3'd0, 32'h000F0);
    bus_write(3'd4, 32'h0000F);
    bus_write(3'd5, 32'h000C0);
    check("pins_setclr", {14'd0, pins}, 32'h0003F);
    settle();
    bus_read(3'd0, 32'h0003F, "rd_setclr");
    bus_read(3'd4, 32'h0, "rd_outset_zero");
    bus_read(3'd5, 32'h0, "rd_outclear_zero");

    // Edge select
    bus_write(3'd1, 32'h0);
    tb_drv = 18'h2;
    tb_oe  = '1;
    settle();
    bus_read(3'd3, 32'h0, "edge_none_yet");
    bus_write(3'd6, 32'h1);
    bus_write(3'd7, 32'h2);
    bus_write(3'd2, 32'h3);
    tb_drv = 18'h3;
    repeat (LAT) @(posedge clk); #1;
    check("irq_before_rise", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_after_rise", {31'd0, irq}, 32'd1);
    bus_read(3'd3, 32'h1, "edge_rise_pin0");
    tb_drv = 18'h1;
    settle();
    bus_read(3'd3, 32'h3, "edge_fall_pin1");
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h2, "edge_clear_bit0");
    check("irq_bit1_pending", {31'd0, irq}, 32'd1);
    bus_write(3'd3, 32'h2);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    bus_read(3'd3, 32'h0, "edge_all_clear");

    // Edge and write-1-clear in the same cycle
    tb_drv = 18'h0;
    settle();
    bus_read(3'd3, 32'h0, "edge_fall_not_en");
    tb_drv = 18'h1;
    repeat (LAT) @(posedge clk); #1;
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h1, "edge_set_wins");
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, 32'h0, "edge_clear_after");

`ifdef GPIO_DEBOUNCE_EN
    // Debounce on pin3
    bus_write(3'd6, 32'h8);
    bus_write(3'd7, 32'h0);
    bus_write(3'd2, 32'h8);
    tb_drv = 18'h9;
    repeat (5) @(posedge clk); #1;
    tb_drv = 18'h1;
    settle();
    bus_read(3'd3, 32'h0, "db_glitch_edge");
    bus_read(3'd0, 32'h1, "db_glitch_pin_in");
    tb_drv = 18'h9;
    repeat (LAT) @(posedge clk); #1;
    check("db_irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("db_irq_after", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    tb_drv = 18'h1;
    bus_read(3'd3, 32'h8, "db_edge_pin3");
    settle();
    bus_read(3'd0, 32'h1, "db_pin3_low");
    bus_write(3'd3, 32'h8);
`endif

    // Reset mid-operation
    bus_write(3'd6, 32'h0);
    bus_write(3'd7, 32'h0);
    tb_drv = 18'h0;
    settle();
    bus_write(3'd3, 32'h3FFFF);
    bus_write(3'd0, 32'h0);
    bus_write(3'd6, 32'h4);
    bus_write(3'd2, 32'h4);
    tb_oe = '0;
    bus_write(3'd1, 32'h3FFFF);
    settle();
    bus_write(3'd0, 32'h1234);
    settle();
    check("irq_pre_reset", {31'd0, irq}, 32'd1);
    check("pins_pre_reset", {14'd0, pins}, 32'h1234);
    #3;
    reset_n = 1'b0;
    tb_drv  = 18'h1;
    tb_oe   = '1;
    #1;
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    check("pins_async_hiz", {14'd0, pins}, 32'h1);
    check("readdata_async_reset", readdata, 32'h0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    settle();
    bus_write(3'd6, 32'h1);
    settle();
    bus_read(3'd3, 32'h0, "no_edge_high_at_reset");
    bus_read(3'd0, 32'h1, "pin_in_after_reset");
    check("irq_after_reset", {31'd0, irq}, 32'd0);
    tb_oe = '0;
    bus_write(3'd1, 32'h3FFFF);
    check("pins_data_out_reset", {14'd0, pins}, {14'd0, RST_OUT});

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
